// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// write-through-when-full on a simultaneous read, and sticky error flags.
module fifo_sync_param #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned AFULL_TH  = 3,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WIDTH-1:0]  din,
  input  logic              writep,
  input  logic              readp,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  dout,
  output logic [ADDR_W:0]   count,
  output logic              emptyp,
  output logic              fullp,
  output logic              almost_emptyp,
  output logic              almost_fullp,
  output logic              ovf,
  output logic              udf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_V  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_V  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_V = CW'(AEMPTY_TH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic              rd_en;
  logic              wr_en;

  // Request qualification; a write when full only goes through alongside a read
  always_comb begin
    rd_en = readp & ~emptyp;
    wr_en = writep & (~fullp | readp);
  end

  // Status flags decoded from the registered occupancy count
  always_comb begin
    emptyp        = (count == '0);
    fullp         = (count == DEPTH_V);
    almost_emptyp = (count <= AEMPTY_V);
    almost_fullp  = (count >= AFULL_V);
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[head] <= din;
  end

  // Pointers, count and read data register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_en) head <= head + ADDR_W'(1);
      if (rd_en) begin
        tail <= tail + ADDR_W'(1);
        dout <= mem[tail];
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a fresh error outranks a coincident clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (writep & ~wr_en) | (ovf & ~clr_err);
      udf <= (readp & ~rd_en) | (udf & ~clr_err);
    end
  end

endmodule
